// File: rtl/serial_adder_pkg.sv
// Shared FSM state encoding for the bit-serial add/subtract controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell; the only arithmetic element of the serial datapath.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial A+B / A-B unit: one full-adder cell, LSB first, WIDTH cycles per operation.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_ovf;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_last;

  fulladder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B on capture and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
          r_carry <= w_fa_cout;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          // Counter holds at WIDTH-1 instead of wrapping on the final bit.
          if (w_last) r_ovf <= r_carry ^ w_fa_cout;
          else        r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done     = (r_state == ST_DONE);
  assign sum      = r_sum;
  assign cout     = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unsigned result modulo 2^W, carry/no-borrow, and signed range overflow.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [W-1:0] r, output logic c, output logic ov);
    longint ux, uy, sx, sy, rr, sr;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - (longint'(1) << W) : ux;
    sy = y[W-1] ? uy - (longint'(1) << W) : uy;
    if (s) begin
      rr = ux - uy;
      c  = (ux >= uy);
      sr = sx - sy;
    end else begin
      rr = ux + uy;
      c  = (rr >= (longint'(1) << W));
      sr = sx + sy;
    end
    r  = rr[W-1:0];
    ov = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] er;
    logic         ec, eo;
    int           n;
    model(x, y, s, er, ec, eo);
    a = x; b = y; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check({tag, ":busy1"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 3 * int'(W)) begin
      tick();
      n++;
    end
    check({tag, ":lat"}, 32'(n), 32'(W + 1));
    check({tag, ":sum"}, 32'(sum), 32'(er));
    check({tag, ":cout"}, 32'(cout), 32'(ec));
    check({tag, ":ovf"}, 32'(overflow), 32'(eo));
    tick();
    check({tag, ":pulse"}, 32'(done), 32'd0);
    check({tag, ":idle"}, 32'(busy), 32'd0);
    check({tag, ":hold"}, 32'(sum), 32'(er));
  endtask

  initial begin
    int dcnt, prev, last_done;
    logic [W-1:0] rx, ry;
    logic         rs;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:sum", 32'(sum), 32'd0);
    check("rst:cout", 32'(cout), 32'd0);
    check("rst:ovf", 32'(overflow), 32'd0);

    // start coincident with rst must be dropped
    rst = 1'b1; start = 1'b1; a = 8'h33; b = 8'h44;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rststart:busy", 32'(busy), 32'd0);
    tick();
    check("rststart:busy2", 32'(busy), 32'd0);

    run_op("add0F01", 8'h0F, 8'h01, 1'b0);
    run_op("addFF01", 8'hFF, 8'h01, 1'b0);
    run_op("add7F01", 8'h7F, 8'h01, 1'b0);
    run_op("sub0507", 8'h05, 8'h07, 1'b1);
    run_op("sub8001", 8'h80, 8'h01, 1'b1);

    // start pulse during RUN cycle 3 is ignored
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'h11;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        dcnt++;
        check("ign:sum", 32'(sum), 32'h03);
      end
      tick();
    end
    check("ign:ndone", 32'(dcnt), 32'd1);

    // reset at RUN cycle 4 aborts
    a = 8'hAB; b = 8'h5C; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    check("abort:sum", 32'(sum), 32'd0);
    check("abort:cout", 32'(cout), 32'd0);
    check("abort:ovf", 32'(overflow), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("abort:nodone", 32'(dcnt), 32'd0);
    run_op("postabort", 8'hAB, 8'h5C, 1'b0);

    // start held high: back-to-back operations every WIDTH+2 cycles
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    dcnt = 0; prev = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        dcnt++;
        check("held:sum", 32'(sum), 32'h02);
        if (prev >= 0) check("held:gap", 32'(i - prev), 32'(W + 2));
        prev = i;
      end
    end
    start = 1'b0;
    check("held:ndone", 32'(dcnt), 32'd3);
    last_done = 0;
    while (busy && last_done < 30) begin
      tick();
      last_done++;
    end
    check("held:drain", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) rx = '1;
      if (i % 8 == 1) ry = '0;
      run_op($sformatf("rnd%0d", i), rx, ry, rs);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
